// File: rtl/wr_control_pkg.sv
// Shared definitions for the read/write control sequencers.
//   state_t : sequencer state encoding (IDLE, FILL, DRAIN, DONE)
//   LANE_AW : width of one lane's output-memory address
package wr_control_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FILL  = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam int LANE_AW = 8;

endpackage

// File: rtl/wr_lane_addr.sv
// Per-lane write address counter.
//   clk, reset : clock and synchronous active-high reset
//   load       : load base (takes priority over inc)
//   inc        : advance the address by one (wraps modulo 2^LANE_AW)
//   base       : start address
//   addr       : registered current address
module wr_lane_addr
  import wr_control_pkg::*;
(
  input  logic               clk,
  input  logic               reset,
  input  logic               load,
  input  logic               inc,
  input  logic [LANE_AW-1:0] base,
  output logic [LANE_AW-1:0] addr
);

  always_ff @(posedge clk) begin
    if (reset) begin
      addr <= '0;
    end else if (load) begin
      addr <= base;
    end else if (inc) begin
      addr <= addr + 1'b1;
    end
  end

endmodule

// File: rtl/wr_control.sv
// Output-write sequencer: produces a diagonal write-enable wave over
// width_height lanes plus per-lane write addresses, then a done pulse.
//   clk, reset : clock and synchronous active-high reset
//   active     : start trigger (level or pulse), ignored while busy
//   base_addr  : start address for every lane, captured on start
//   wr_en      : per-lane write enable, bit i = lane i
//   wr_addr    : per-lane address, lane i at [8i+7:8i]
//   busy       : high whenever not IDLE
//   done       : one-cycle completion pulse
module wr_control
  import wr_control_pkg::*;
#(
  parameter  int width_height = 16,
  localparam int addr_width   = 8,
  localparam int data_width   = width_height * 8
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    active,
  input  logic [addr_width-1:0]   base_addr,
  output logic [width_height-1:0] wr_en,
  output logic [data_width-1:0]   wr_addr,
  output logic                    busy,
  output logic                    done
);

  localparam int CW = $clog2(width_height) + 1;
  localparam logic [CW-1:0] N_CNT = CW'(width_height);
  localparam logic [width_height-1:0] LANE0 = {{(width_height-1){1'b0}}, 1'b1};

  state_t                  state_reg, state_next;
  logic [CW-1:0]           cnt_reg, cnt_next;
  logic [width_height-1:0] wr_en_reg, wr_en_next;
  logic                    busy_reg, busy_next;
  logic                    done_reg, done_next;
  logic                    start;

  assign start = (state_reg == IDLE) && active;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= IDLE;
      cnt_reg   <= '0;
      wr_en_reg <= '0;
      busy_reg  <= 1'b0;
      done_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      wr_en_reg <= wr_en_next;
      busy_reg  <= busy_next;
      done_reg  <= done_next;
    end
  end

  // cnt_reg holds the 1-based index of the current FILL/DRAIN cycle, so
  // the phase ends on the edge after the cycle where it equals N.
  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    wr_en_next = wr_en_reg;
    busy_next  = busy_reg;
    done_next  = 1'b0;
    case (state_reg)
      IDLE: begin
        cnt_next   = '0;
        wr_en_next = '0;
        busy_next  = 1'b0;
        if (active) begin
          state_next = FILL;
          cnt_next   = CW'(1);
          wr_en_next = LANE0;
          busy_next  = 1'b1;
        end
      end
      FILL: begin
        if (cnt_reg == N_CNT) begin
          // All lanes are on; the first shifted-in zero starts the drain.
          state_next = DRAIN;
          cnt_next   = CW'(1);
          wr_en_next = {wr_en_reg[width_height-2:0], 1'b0};
        end else begin
          cnt_next   = cnt_reg + 1'b1;
          wr_en_next = {wr_en_reg[width_height-2:0], 1'b1};
        end
      end
      DRAIN: begin
        wr_en_next = {wr_en_reg[width_height-2:0], 1'b0};
        if (cnt_reg == N_CNT) begin
          state_next = DONE;
          cnt_next   = '0;
          done_next  = 1'b1;
        end else begin
          cnt_next = cnt_reg + 1'b1;
        end
      end
      DONE: begin
        state_next = IDLE;
        cnt_next   = '0;
        wr_en_next = '0;
        busy_next  = 1'b0;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Each lane advances on the edge after a cycle in which it was enabled,
  // so the address shown with wr_en[i] is the one being written.
  generate
    for (genvar gi = 0; gi < width_height; gi++) begin : g_lane
      wr_lane_addr u_lane (
        .clk   (clk),
        .reset (reset),
        .load  (start),
        .inc   (wr_en_reg[gi]),
        .base  (base_addr),
        .addr  (wr_addr[gi*addr_width +: addr_width])
      );
    end
  endgenerate

  assign wr_en = wr_en_reg;
  assign busy  = busy_reg;
  assign done  = done_reg;

endmodule

// File: tb/tb_wr_control.sv
module tb_wr_control;

  localparam int N  = 16;
  localparam int DW = N * 8;

  logic          clk = 1'b0;
  logic          reset;
  logic          active;
  logic [7:0]    base_addr;
  logic [N-1:0]  wr_en;
  logic [DW-1:0] wr_addr;
  logic          busy;
  logic          done;

  int vectors = 0;
  int miscompares = 0;

  wr_control #(.width_height(N)) dut (
    .clk       (clk),
    .reset     (reset),
    .active    (active),
    .base_addr (base_addr),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .busy      (busy),
    .done      (done)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  // Model: k = cycles since the accepted start (0 = idle). The wave spans
  // k = 1..2N, done appears at k = 2N+1, idle again afterwards.
  int            k = 0;
  logic [7:0]    base_m = '0;
  logic [7:0]    hold_m [N];
  bit            model_valid = 1'b0;
  logic [N-1:0]  exp_wr_en;
  logic [DW-1:0] exp_wr_addr;
  logic          exp_busy, exp_done;

  always @(posedge clk) begin
    model_valid = 1'b1;
    if (reset) begin
      k = 0;
      for (int i = 0; i < N; i++) hold_m[i] = 8'h00;
    end else if (k == 0) begin
      if (active) begin
        k = 1;
        base_m = base_addr;
      end
    end else if (k == 2*N + 1) begin
      k = 0;
    end else begin
      k = k + 1;
    end
    exp_wr_en = '0;
    for (int i = 0; i < N; i++) begin
      if (k >= 1) begin
        int used;
        used = k - 1 - i;
        if (used < 0) used = 0;
        if (used > N) used = N;
        hold_m[i] = base_m + 8'(used);
        if (k <= 2*N && i <= k - 1 && i >= k - N) exp_wr_en[i] = 1'b1;
      end
      exp_wr_addr[i*8 +: 8] = hold_m[i];
    end
    exp_busy = (k != 0);
    exp_done = (k == 2*N + 1);
  end

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (model_valid) begin
      check("cyc_wr_en", DW'(wr_en), DW'(exp_wr_en));
      check("cyc_wr_addr", wr_addr, exp_wr_addr);
      check("cyc_busy", DW'(busy), DW'(exp_busy));
      check("cyc_done", DW'(done), DW'(exp_done));
    end
  end

  function automatic logic [7:0] lane(input int i);
    return wr_addr[i*8 +: 8];
  endfunction

  int t;

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic goto(input int target);
    tick(target - t);
    t = target;
  endtask

  // Drive active with base for one edge; returns at T+1 (first wr_en).
  task automatic start_wave(input logic [7:0] b, input bit keep);
    active = 1'b1;
    base_addr = b;
    tick(1);
    if (!keep) active = 1'b0;
    t = 1;
  endtask

  initial begin
    reset = 1'b1;
    active = 1'b0;
    base_addr = 8'h00;
    tick(3);
    check("rst_wr_en", DW'(wr_en), '0);
    check("rst_wr_addr", wr_addr, '0);
    check("rst_busy", DW'(busy), '0);
    check("rst_done", DW'(done), '0);
    reset = 1'b0;
    tick(1);

    // Single wave from 0x20, with an ignored active pulse during FILL.
    start_wave(8'h20, 1'b0);
    $display("run1 start base=20");
    check("r1_t1_wr_en", DW'(wr_en), DW'(16'h0001));
    check("r1_t1_lane0", DW'(lane(0)), DW'(8'h20));
    goto(5); active = 1'b1;
    goto(6); active = 1'b0;
    goto(10);
    check("r1_t10_wr_en", DW'(wr_en), DW'(16'h03FF));
    goto(16);
    check("r1_t16_wr_en", DW'(wr_en), DW'(16'hFFFF));
    check("r1_t16_lane0", DW'(lane(0)), DW'(8'h2F));
    check("r1_t16_lane15", DW'(lane(15)), DW'(8'h20));
    goto(17);
    check("r1_t17_wr_en", DW'(wr_en), DW'(16'hFFFE));
    check("r1_t17_lane0", DW'(lane(0)), DW'(8'h30));
    goto(31);
    check("r1_t31_wr_en", DW'(wr_en), DW'(16'h8000));
    check("r1_t31_lane15", DW'(lane(15)), DW'(8'h2F));
    goto(32);
    check("r1_t32_wr_en", DW'(wr_en), '0);
    check("r1_t32_done", DW'(done), '0);
    goto(33);
    check("r1_t33_done", DW'(done), DW'(1'b1));
    check("r1_t33_busy", DW'(busy), DW'(1'b1));
    goto(34);
    check("r1_t34_done", DW'(done), '0);
    check("r1_t34_busy", DW'(busy), '0);
    check("r1_final_addr", wr_addr, {N{8'h30}});
    tick(2);

    // Address wrap from 0xF8.
    start_wave(8'hF8, 1'b0);
    $display("run2 start base=F8");
    goto(8);
    check("r2_t8_lane0", DW'(lane(0)), DW'(8'hFF));
    goto(9);
    check("r2_t9_lane0", DW'(lane(0)), DW'(8'h00));
    check("r2_t9_busy", DW'(busy), DW'(1'b1));
    goto(16);
    check("r2_t16_lane0", DW'(lane(0)), DW'(8'h07));
    check("r2_t16_wr_en", DW'(wr_en), DW'(16'hFFFF));
    goto(33);
    check("r2_t33_done", DW'(done), DW'(1'b1));
    goto(34);
    check("r2_final_addr", wr_addr, {N{8'h08}});
    tick(2);

    // active held high: back-to-back waves with one IDLE cycle between.
    start_wave(8'h40, 1'b1);
    $display("run3 start base=40 active held");
    goto(33);
    check("r3_t33_done", DW'(done), DW'(1'b1));
    goto(34);
    check("r3_t34_wr_en", DW'(wr_en), '0);
    check("r3_t34_busy", DW'(busy), '0);
    goto(35);
    check("r3_t35_wr_en", DW'(wr_en), DW'(16'h0001));
    check("r3_t35_lane0", DW'(lane(0)), DW'(8'h40));
    goto(50);
    check("r3_t50_wr_en", DW'(wr_en), DW'(16'hFFFF));
    goto(60);
    active = 1'b0;
    goto(67);
    check("r3_t67_done", DW'(done), DW'(1'b1));
    goto(70);
    check("r3_t70_busy", DW'(busy), '0);
    check("r3_t70_wr_en", DW'(wr_en), '0);

    // Reset mid-wave, then a clean restart from 0x05.
    start_wave(8'h20, 1'b0);
    $display("run4 start base=20, reset at T+10");
    goto(10);
    check("r4_t10_wr_en", DW'(wr_en), DW'(16'h03FF));
    reset = 1'b1;
    active = 1'b1;
    tick(1);
    check("r4_rst_wr_en", DW'(wr_en), '0);
    check("r4_rst_wr_addr", wr_addr, '0);
    check("r4_rst_busy", DW'(busy), '0);
    check("r4_rst_done", DW'(done), '0);
    reset = 1'b0;
    active = 1'b0;
    tick(2);
    start_wave(8'h05, 1'b0);
    $display("run5 start base=05");
    check("r5_t1_wr_en", DW'(wr_en), DW'(16'h0001));
    check("r5_t1_lane0", DW'(lane(0)), DW'(8'h05));
    goto(33);
    check("r5_t33_done", DW'(done), DW'(1'b1));
    goto(34);
    check("r5_final_addr", wr_addr, {N{8'h15}});
    tick(2);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
